mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, 8, consecutive lost arbitration cycles after which a waiting ifetch request is forced through (fixed-priority mode only).
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 if_req_i  in  1  ifetch request; held with if_adr_i until if_gnt_o.
REQ-005 if_adr_i  in  XLEN  fetch address.
REQ-006 if_gnt_o  out  1  fetch accepted by memory.
REQ-007 if_rvalid_o  out  1  fetch data valid, one cycle.
REQ-008 if_rdata_o  out  32  fetched instruction.
REQ-009 d_req_i  in  1  data request; held with d_* fields until d_gnt_o.
REQ-010 d_adr_i / d_we_i / d_wdata_i / d_size_i  in  XLEN/1/XLEN/3  address, store flag, store data, access size.
REQ-011 d_gnt_o  out  1  data access accepted.
REQ-012 d_rvalid_o  out  1  load data valid or store acknowledged, one cycle.
REQ-013 d_rdata_o  out  XLEN  load data; 0 for stores.
REQ-014 m_req_o / m_adr_o / m_we_o / m_wdata_o / m_size_o  out  1/XLEN/1/XLEN/3  unified memory request, all registered.
REQ-015 m_gnt_i  in  1  memory accepts request in current cycle.
REQ-016 m_rvalid_i / m_rdata_i  in  1/XLEN  memory response, one per granted transaction (stores included).

Function
REQ-017 FSM states: IDLE, REQ_IF, REQ_D, RSP_IF, RSP_D; one transaction outstanding at most.
REQ-018 IDLE: any request present -> winner fields latched into m_* registers, next state REQ_IF/REQ_D; m_req_o high the following cycle (1-cycle request latency).
REQ-019 Both requests in IDLE, fixed mode: data wins, unless the ifetch starvation counter equals MAX_WAIT, in which case ifetch wins.
REQ-020 Starvation counter: increments (saturating at MAX_WAIT) each IDLE cycle ifetch requests and loses; cleared when ifetch wins.
REQ-021 REQ_x: m_req_o and m_* fields held stable until m_gnt_i; selection never changes while in REQ_x.
REQ-022 REQ_x with m_gnt_i=1: x_gnt_o=1 in the same cycle (combinational from state and m_gnt_i), next state RSP_x, m_req_o low next cycle.
REQ-023 RSP_x with m_rvalid_i=1: x_rvalid_o=1 and rdata forwarded combinationally in the same cycle (if_rdata_o = m_rdata_i[31:0]); next state IDLE.
REQ-024 New arbitration only in IDLE; minimum back-to-back spacing is request-to-request 3 cycles with zero-wait memory.
REQ-025 m_rvalid_i outside RSP_x is discarded; no x_rvalid_o raised.
REQ-026 Non-owner gnt/rvalid outputs are 0 at all times; if_gnt_o and d_gnt_o never high in the same cycle.
REQ-027 Requester dropping req while in REQ_x does not cancel the transaction; it completes and responds normally.

Reset
REQ-028 reset_n low at a clock edge: state IDLE, m_req_o=0, m_adr_o/m_wdata_o=0, m_we_o=0, m_size_o=0, starvation counter 0, round-robin pointer to data.
REQ-029 Reset mid-transaction abandons it; late m_rvalid_i after reset is discarded per REQ-025.
REQ-030 All x_gnt_o/x_rvalid_o/x_rdata_o are 0 while reset_n is low.

Configuration
REQ-031 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on conflict the requester that did not win the last grant wins; starvation counter and MAX_WAIT unused.
REQ-032 MEM_ARB_RR_EN undefined: fixed data priority with starvation override per REQ-019/REQ-020.

Structure
REQ-033 riscv_pkg holds arb_state_t (five FSM states) and arb_owner_t (ARB_IF, ARB_D); XLEN from riscv_pkg.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Only if_req_i=1, if_adr_i=0x80, m_gnt_i=1 one cycle after m_req_o, m_rvalid_i two cycles later with 0x00000013 -> m_adr_o=0x80, m_we_o=0, if_gnt_o pulse, if_rvalid_o pulse with if_rdata_o=0x00000013.
REQ-036 Both requests in IDLE, d_we_i=1, d_adr_i=0x1000, d_wdata_i=0xDEADBEEF, fixed mode -> data served first (m_we_o=1), d_rvalid_o with d_rdata_o=0, then ifetch served.
REQ-037 d_req_i held high continuously, if_req_i high, fixed mode, MAX_WAIT=8 -> ifetch granted on the 9th contested arbitration; counter back to 0.
REQ-038 MEM_ARB_RR_EN defined, both requesting continuously -> grants strictly alternate D, IF, D, IF.
REQ-039 m_gnt_i held low 5 cycles in REQ_D while if_req_i rises -> m_* fields unchanged, no if_gnt_o, d_gnt_o on 6th cycle.
REQ-040 reset_n low during RSP_IF, then m_rvalid_i=1 after release -> state IDLE, all outputs 0, no if_rvalid_o.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter: FSM states, requester identity, data width.
package riscv_pkg;

    localparam int XLEN = 32;

    // ifetch is always a full 32-bit word access
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_D,
        RSP_IF,
        RSP_D
    } arb_state_t;

    typedef enum logic {
        ARB_IF,
        ARB_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates ifetch and data ports onto one memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin; default is data priority with ifetch starvation override.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [31:0]     if_rdata_o,
    input  logic            d_req_i,
    input  logic [XLEN-1:0] d_adr_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [2:0]      d_size_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            m_req_o,
    output logic [XLEN-1:0] m_adr_o,
    output logic            m_we_o,
    output logic [XLEN-1:0] m_wdata_o,
    output logic [2:0]      m_size_o,
    input  logic            m_gnt_i,
    input  logic            m_rvalid_i,
    input  logic [XLEN-1:0] m_rdata_i
);

    arb_state_t      r_state, w_state_nxt;
    logic            w_arb, w_sel_if;
    logic            r_m_req, r_m_we;
    logic [XLEN-1:0] r_m_adr, r_m_wdata;
    logic [2:0]      r_m_size;

`ifdef MEM_ARB_RR_EN
    // Owner that wins the next conflict; flipped after every arbitration
    arb_owner_t r_rr_prio;

    assign w_sel_if = if_req_i && (!d_req_i || (r_rr_prio == ARB_IF));

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_rr_prio <= ARB_D;
        else if (w_arb)
            r_rr_prio <= w_sel_if ? ARB_D : ARB_IF;
    end
`else
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] r_starve;

    assign w_sel_if = if_req_i && (!d_req_i || (r_starve == CW'(MAX_WAIT)));

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_starve <= '0;
        else if (w_arb) begin
            if (w_sel_if)
                r_starve <= '0;
            else if (if_req_i && (r_starve != CW'(MAX_WAIT)))
                r_starve <= r_starve + CW'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    w_arb       = 1'b1;
                    w_state_nxt = w_sel_if ? REQ_IF : REQ_D;
                end
            end
            REQ_IF:  if (m_gnt_i)    w_state_nxt = RSP_IF;
            REQ_D:   if (m_gnt_i)    w_state_nxt = RSP_D;
            RSP_IF:  if (m_rvalid_i) w_state_nxt = IDLE;
            RSP_D:   if (m_rvalid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_m_adr   <= '0;
            r_m_we    <= 1'b0;
            r_m_wdata <= '0;
            r_m_size  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_m_req <= (w_state_nxt == REQ_IF) || (w_state_nxt == REQ_D);
            // Fields are captured only at arbitration, so they stay frozen through REQ/RSP
            if (w_arb) begin
                r_m_adr   <= w_sel_if ? if_adr_i : d_adr_i;
                r_m_we    <= w_sel_if ? 1'b0 : d_we_i;
                r_m_wdata <= w_sel_if ? '0 : d_wdata_i;
                r_m_size  <= w_sel_if ? SIZE_WORD : d_size_i;
            end
        end
    end

    assign m_req_o   = r_m_req;
    assign m_adr_o   = r_m_adr;
    assign m_we_o    = r_m_we;
    assign m_wdata_o = r_m_wdata;
    assign m_size_o  = r_m_size;

    assign if_gnt_o    = reset_n && (r_state == REQ_IF) && m_gnt_i;
    assign d_gnt_o     = reset_n && (r_state == REQ_D)  && m_gnt_i;
    assign if_rvalid_o = reset_n && (r_state == RSP_IF) && m_rvalid_i;
    assign d_rvalid_o  = reset_n && (r_state == RSP_D)  && m_rvalid_i;
    assign if_rdata_o  = if_rvalid_o ? m_rdata_i[31:0] : 32'h0;
    assign d_rdata_o   = (d_rvalid_o && !r_m_we) ? m_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requesters and memory are modelled here,
// a transaction-level arbitration model predicts each winner and the monitor checks it.
module tb_mem_arbiter;
    import riscv_pkg::*;

    localparam int MAX_WAIT = 8;

    logic        clk, reset_n;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_adr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
    logic [31:0] d_adr_i, d_wdata_i, d_rdata_o;
    logic [2:0]  d_size_i;
    logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i;
    logic [31:0] m_adr_o, m_wdata_o, m_rdata_i;
    logic [2:0]  m_size_o;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
        .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .m_req_o(m_req_o), .m_adr_o(m_adr_o), .m_we_o(m_we_o), .m_wdata_o(m_wdata_o),
        .m_size_o(m_size_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] wdata; logic [2:0] size; } txn_t;
    typedef struct { arb_owner_t owner; logic [31:0] rdata; } rsp_t;

    txn_t       exp_if_q[$], exp_d_q[$];
    rsp_t       rsp_q[$];
    int         n_cmp = 0, n_err = 0;

    // reference arbitration state
    int         mdl_starve = 0;
    arb_owner_t mdl_rr = ARB_D;

    // environment state
    bit         if_pending, d_pending, if_latched, d_latched, mem_out, cur_valid;
    bit         prev_if_req, prev_d_req, last_m_req;
    int         rsp_wait;
    arb_owner_t cur_owner, mon_w;
    txn_t       cur_txn;
    rsp_t       mon_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string act, input string exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual %s required %s at %0t", name, act, exp, $time);
    endtask

    // Winner of one arbitration given who was requesting
    task automatic pick(input bit ifr, input bit dr, output arb_owner_t w);
`ifdef MEM_ARB_RR_EN
        if (ifr && dr) w = mdl_rr;
        else           w = ifr ? ARB_IF : ARB_D;
        mdl_rr = (w == ARB_IF) ? ARB_D : ARB_IF;
`else
        if (ifr && dr) w = (mdl_starve == MAX_WAIT) ? ARB_IF : ARB_D;
        else           w = ifr ? ARB_IF : ARB_D;
        if (w == ARB_IF)  mdl_starve = 0;
        else if (ifr)     mdl_starve = (mdl_starve < MAX_WAIT) ? mdl_starve + 1 : MAX_WAIT;
`endif
    endtask

    // Monitor: samples on the falling edge, between input updates
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("outs_in_reset", {28'h0, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}, 32'h0);
            chk("rdata_in_reset", if_rdata_o | d_rdata_o, 32'h0);
            mdl_starve = 0; mdl_rr = ARB_D;
            mem_out = 0; cur_valid = 0; if_pending = 0; d_pending = 0;
            if_latched = 0; d_latched = 0;
            rsp_q.delete(); exp_if_q.delete(); exp_d_q.delete();
            prev_if_req = 0; prev_d_req = 0; last_m_req = 0;
        end else begin
            if (m_req_o && !last_m_req) begin
                if (!prev_if_req && !prev_d_req) begin
                    fail("spurious_m_req", "m_req_o=1", "no request");
                    cur_valid = 0;
                end else begin
                    pick(prev_if_req, prev_d_req, mon_w);
                    cur_owner = mon_w;
                    if (mon_w == ARB_IF && exp_if_q.size() != 0) begin
                        cur_txn = exp_if_q.pop_front(); cur_valid = 1; if_latched = 1;
                    end else if (mon_w == ARB_D && exp_d_q.size() != 0) begin
                        cur_txn = exp_d_q.pop_front(); cur_valid = 1; d_latched = 1;
                    end else begin
                        fail("winner_queue", "empty", "pending txn");
                        cur_valid = 0;
                    end
                end
            end
            if (m_req_o && cur_valid) begin
                chk("m_adr", m_adr_o, cur_txn.adr);
                chk("m_we", {31'h0, m_we_o}, {31'h0, cur_txn.we});
                if (cur_owner == ARB_D) begin
                    chk("m_wdata", m_wdata_o, cur_txn.wdata);
                    chk("m_size", {29'h0, m_size_o}, {29'h0, cur_txn.size});
                end
            end
            begin
                bit hs;
                hs = m_req_o && m_gnt_i && cur_valid;
                if (hs || if_gnt_o)
                    chk("if_gnt", {31'h0, if_gnt_o}, {31'h0, hs && cur_owner == ARB_IF});
                if (hs || d_gnt_o)
                    chk("d_gnt", {31'h0, d_gnt_o}, {31'h0, hs && cur_owner == ARB_D});
            end
            if (if_rvalid_o || d_rvalid_o) begin
                if (rsp_q.size() == 0) fail("spurious_rvalid", "rvalid=1", "no response due");
                else begin
                    mon_r = rsp_q.pop_front();
                    chk("rvalid_owner", {30'h0, if_rvalid_o, d_rvalid_o},
                        (mon_r.owner == ARB_IF) ? 32'h2 : 32'h1);
                    chk("rdata", (mon_r.owner == ARB_IF) ? if_rdata_o : d_rdata_o, mon_r.rdata);
                end
            end
            if (rsp_q.size() != 0) begin
                fail("missing_rvalid", "rvalid=0", "response");
                rsp_q.delete();
            end
            if (m_rvalid_i && mem_out) begin mem_out = 0; cur_valid = 0; end
            if (m_req_o && m_gnt_i) begin mem_out = 1; rsp_wait = $urandom_range(2); end
            if (if_gnt_o) if_pending = 0;
            if (d_gnt_o)  d_pending = 0;
            last_m_req  = m_req_o;
            prev_if_req = if_req_i;
            prev_d_req  = d_req_i;
        end
    end

    // One cycle of requester and memory behaviour, driven just after the rising edge
    task automatic drive_env(input bit issue, input int if_rate, input int d_rate);
        txn_t t;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = $urandom;
        if (m_req_o) m_gnt_i = ($urandom_range(2) != 0);
        if (mem_out) begin
            if (rsp_wait > 0) rsp_wait--;
            else begin
                m_rvalid_i = 1'b1;
                t = cur_txn;
                rsp_q.push_back('{cur_owner,
                    (cur_owner == ARB_D && t.we) ? 32'h0 : m_rdata_i});
            end
        end else if ($urandom_range(7) == 0) m_rvalid_i = 1'b1;

        if (!if_pending) begin
            if (issue && $urandom_range(if_rate - 1) == 0) begin
                t.adr = $urandom & 32'hFFFF_FFFC; t.we = 1'b0; t.wdata = 32'h0; t.size = SIZE_WORD;
                exp_if_q.push_back(t);
                if_req_i = 1'b1; if_adr_i = t.adr; if_pending = 1; if_latched = 0;
            end else if_req_i = 1'b0;
        end else if (if_latched && $urandom_range(5) == 0) begin
            if_req_i = 1'b0; if_adr_i = $urandom;
        end

        if (!d_pending) begin
            if (issue && $urandom_range(d_rate - 1) == 0) begin
                t.adr = $urandom; t.we = $urandom_range(1) == 1; t.wdata = $urandom;
                t.size = 3'($urandom_range(2));
                exp_d_q.push_back(t);
                d_req_i = 1'b1; d_adr_i = t.adr; d_we_i = t.we; d_wdata_i = t.wdata;
                d_size_i = t.size; d_pending = 1; d_latched = 0;
            end else d_req_i = 1'b0;
        end else if (d_latched && $urandom_range(5) == 0) begin
            d_req_i = 1'b0; d_adr_i = $urandom; d_wdata_i = $urandom; d_we_i = ~d_we_i;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1);
    end

    initial begin
        bit done;
        reset_n = 1'b0;
        if_req_i = 0; if_adr_i = 0; d_req_i = 0; d_adr_i = 0; d_we_i = 0; d_wdata_i = 0;
        d_size_i = 0; m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_req", {31'h0, m_req_o}, 32'h0);
        chk("rst_m_adr", m_adr_o, 32'h0);
        chk("rst_m_we", {31'h0, m_we_o}, 32'h0);
        chk("rst_m_wdata", m_wdata_o, 32'h0);
        chk("rst_m_size", {29'h0, m_size_o}, 32'h0);
        reset_n = 1'b1;

        // heavy data pressure exercises the starvation override / alternation
        repeat (1500) begin @(posedge clk); #1; drive_env(1'b1, 2, 1); end
        repeat (2500) begin @(posedge clk); #1; drive_env(1'b1, 3, 3); end

        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk); #1;
            drive_env(1'b0, 1, 1);
            done = !if_pending && !d_pending && !mem_out && !m_req_o;
        end
        if (!done) fail("drain_timeout", "transactions pending", "all completed");

        // ifetch reset while waiting for its response; late response must vanish
        @(posedge clk); #1;
        m_gnt_i = 0; m_rvalid_i = 0; d_req_i = 0;
        exp_if_q.push_back('{32'h80, 1'b0, 32'h0, SIZE_WORD});
        if_req_i = 1; if_adr_i = 32'h80; if_pending = 1; if_latched = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk); #1;
            done = m_req_o;
        end
        if (!done) fail("ifetch_req_timeout", "m_req_o=0", "m_req_o=1");
        m_gnt_i = 1;
        @(posedge clk); #1;
        m_gnt_i = 0; if_req_i = 0; reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1; m_rvalid_i = 1; m_rdata_i = 32'h0000_0013;
        #3;
        chk("late_rvalid_if", {31'h0, if_rvalid_o}, 32'h0);
        chk("late_rvalid_d", {31'h0, d_rvalid_o}, 32'h0);
        chk("late_rdata", if_rdata_o, 32'h0);
        chk("post_rst_m_req", {31'h0, m_req_o}, 32'h0);
        chk("post_rst_m_adr", m_adr_o, 32'h0);
        @(posedge clk); #1;
        m_rvalid_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", {31'h0, m_req_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
